fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the five-stage ARM pipeline. It owns the program counter, drives a ready/valid instruction-memory port that tolerates wait states, and applies branch redirects, freezes and flushes. It presents the fetched instruction and PC+4 to the decode stage through a built-in IF/ID output register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hazard stall; holds PC and output register
- flush  in  1  invalidates the output register (bubble to decode)
- branch_taken  in  1  redirect request from execute
- branch_addr  in  32  redirect target, valid when branch_taken=1
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  word address of request; bits [1:0] always 0
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory completes the current request this cycle
- if_pc  out  32  PC+4 of the instruction in the output register
- if_instruction  out  32  fetched instruction
- if_valid  out  1  output register holds a live instruction

## Operation
- Registers: pc, tgt (pending redirect), buf (held instruction), state, and the output register {if_pc, if_instruction, if_valid}.
- Memory rule: while imem_req=1, imem_addr stays stable until imem_ready. A request is never abandoned.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - imem_ready & branch_taken: discard rdata; pc<=branch_addr; stay in FETCH.
  - imem_ready & freeze: buf<=rdata; go to HOLD. pc does not change.
  - imem_ready otherwise: load the output register with {pc+4, rdata, 1}; pc<=pc+4.
  - !imem_ready & branch_taken: tgt<=branch_addr; go to DRAIN.
- DRAIN state:
  - imem_req=1, imem_addr=pc (old address).
  - A new branch_taken overwrites tgt.
  - On imem_ready: discard rdata; pc<=tgt (or branch_addr if branch_taken is asserted the same cycle); go to FETCH.
- HOLD state:
  - imem_req=0.
  - branch_taken: drop buf; pc<=branch_addr; go to FETCH.
  - Otherwise, once !freeze: load the output register with {pc+4, buf, 1}; pc<=pc+4; go to FETCH.
- Output register priority, highest first:
  - rst: all fields zero.
  - flush or branch_taken: if_valid<=0; pc and instruction fields are don't-care but held.
  - freeze: hold all fields.
  - Load as described above.
  - Otherwise: if_valid<=0 (bubble).
- PC arithmetic: 32-bit unsigned; 32'hFFFF_FFFC+4 wraps to 0. branch_addr[1:0] is forced to 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - if_pc=0, if_instruction=0, if_valid=0.
  - imem_req=1, imem_addr=RESET_PC (combinational from state/pc).
- imem_req and imem_addr are combinational from registered state only, never from inputs.
- Zero-wait memory (imem_ready tied 1): one instruction per cycle. if_valid first rises on the edge after reset release.
- N wait cycles: one instruction per N+1 cycles; if_valid is a one-cycle pulse per instruction.
- Branch latency: the target is requested the cycle after branch_taken in FETCH/HOLD. In DRAIN, it is requested the cycle after the outstanding ready.
- The cycle that asserts branch_taken never produces if_valid=1 on the next edge.
- freeze and branch_taken together: the branch wins for both pc and output register.
- Reset mid-request or mid-DRAIN: the state machine returns to FETCH immediately. tgt and buf contents are irrelevant after reset.

## Structure
- Shared package arm_pkg holds:
  - fetch_state_e {FETCH, DRAIN, HOLD}
  - INSTR_W=32, ADDR_W=32
  - PC_STEP=4
- One sub-module, fetch_out_reg: the IF/ID output register with rst/flush/freeze/load priority, reusable by the other stage registers.

## Test plan
- Zero-wait memory returning rdata=addr^32'hA5A5_0000, RESET_PC=0 -> after reset, if_pc=4,8,12… and if_valid=1 every cycle.
- imem_ready every 3rd cycle -> imem_addr stable across wait cycles; if_valid pulses once per 3 cycles; if_pc=4,8,12.
- branch_taken=1, branch_addr=32'h100 during a wait cycle (DRAIN) -> the stale instruction is discarded; the next imem_addr after ready is 32'h100; the next valid output has if_pc=32'h104.
- freeze for 4 cycles while a response arrives -> HOLD with imem_req=0 and outputs unchanged; after release, the held word appears with the correct if_pc; no duplicate or dropped instruction.
- flush=1 for one cycle with zero-wait memory -> if_valid=0 for exactly one cycle; pc sequence unaffected.
- rst asserted mid-DRAIN, PC=32'hFFFF_FFFC wrap check -> all outputs return to reset values asynchronously; the wrap test gives next imem_addr=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline front end.
// Holds the fetch FSM encoding, the IF/ID payload layout and PC helpers.
package arm_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Payload carried from IF to ID alongside the valid bit.
  typedef struct packed {
    addr_t  pc4;
    instr_t instr;
  } ifid_t;

  function automatic addr_t word_align(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic addr_t pc_inc(input addr_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory ready/valid port between the fetch stage and memory.
// The request side holds the address stable until ready is seen.
interface fetch_stage_if;
  import arm_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  instr_t imem_rdata;
  logic   imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Generic pipeline stage register with valid bit.
// Priority: reset, flush (drop valid), freeze (hold), load, otherwise bubble.
module fetch_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         freeze_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         valid_q;
  logic         valid_d;

  // The payload is only ever overwritten by a load; a flush leaves it in place.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (freeze_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a wait-state tolerant
// memory port and handles redirects, freezes and flushes into the IF/ID register.
module fetch_stage
  import arm_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  addr_t             branch_addr_i,
  fetch_stage_if.master     imem,
  output addr_t             if_pc_o,
  output instr_t            if_instruction_o,
  output logic              if_valid_o
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        tgt_q, tgt_d;
  instr_t       buf_q, buf_d;

  addr_t        br_tgt;
  logic         load;
  instr_t       load_instr;
  ifid_t        load_data;
  ifid_t        out_q;

  assign br_tgt = word_align(branch_addr_i);

  // Memory port depends on registered state only, so the address cannot
  // move while a request is waiting on ready.
  assign imem.imem_req  = (state_q != HOLD);
  assign imem.imem_addr = word_align(pc_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    buf_d      = buf_q;
    load       = 1'b0;
    load_instr = imem.imem_rdata;
    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (branch_taken_i) begin
            pc_d = br_tgt;
          end else if (freeze_i) begin
            buf_d   = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_inc(pc_q);
          end
        end else if (branch_taken_i) begin
          tgt_d   = br_tgt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the abandoned path and is discarded.
        if (branch_taken_i) begin
          tgt_d = br_tgt;
        end
        if (imem.imem_ready) begin
          pc_d    = branch_taken_i ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        load_instr = buf_q;
        if (branch_taken_i) begin
          pc_d    = br_tgt;
          state_d = FETCH;
        end else if (!freeze_i) begin
          load    = 1'b1;
          pc_d    = pc_inc(pc_q);
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= word_align(RESET_PC);
      tgt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
    end
  end

  assign load_data.pc4   = pc_inc(pc_q);
  assign load_data.instr = load_instr;

  // A redirect kills whatever would have been presented this cycle.
  fetch_out_reg #(
    .W ($bits(ifid_t))
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i | branch_taken_i),
    .freeze_i (freeze_i),
    .load_i   (load),
    .data_i   (load_data),
    .data_o   (out_q),
    .valid_o  (if_valid_o)
  );

  assign if_pc_o          = out_q.pc4;
  assign if_instruction_o = out_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against an address-level
// reference model; memory returns addr ^ KEY and garbage when not ready.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        bt;
  logic [31:0] baddr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural PC, optional redirect waiting on an
  // in-flight response, optional word parked by a freeze, and the IF/ID view.
  logic [31:0] m_pc;
  logic        m_drain;
  logic [31:0] m_tgt;
  logic        m_held;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;

  fetch_stage_if ifc ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze_i         (freeze),
    .flush_i          (flush),
    .branch_taken_i   (bt),
    .branch_addr_i    (baddr),
    .imem             (ifc),
    .if_pc_o          (if_pc),
    .if_instruction_o (if_instr),
    .if_valid_o       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_drain  = 1'b0;
    m_tgt    = 32'h0;
    m_held   = 1'b0;
    m_valid  = 1'b0;
    m_opc    = 32'h0;
    m_oinstr = 32'h0;
  endtask

  // Called at a falling edge; applies inputs for one cycle and checks both
  // the combinational memory port and the registered outputs after the edge.
  task automatic step(input logic rdy, input logic f, input logic fl,
                      input logic b, input logic [31:0] ba);
    logic [31:0] ba_al;
    logic [31:0] n_pc;
    logic        n_drain;
    logic [31:0] n_tgt;
    logic        n_held;
    logic        deliver;
    ifc.imem_ready = rdy;
    freeze = f;
    flush  = fl;
    bt     = b;
    baddr  = ba;
    ifc.imem_rdata = rdy ? (ifc.imem_addr ^ KEY) : 32'($urandom);
    #1;
    check("imem_req", 32'(ifc.imem_req), 32'(!m_held));
    if (!m_held) check("imem_addr", ifc.imem_addr, m_pc);

    ba_al   = {ba[31:2], 2'b00};
    n_pc    = m_pc;
    n_drain = m_drain;
    n_tgt   = m_tgt;
    n_held  = m_held;
    deliver = 1'b0;
    if (m_held) begin
      if (b) begin
        n_pc   = ba_al;
        n_held = 1'b0;
      end else if (!f) begin
        deliver = 1'b1;
        n_held  = 1'b0;
      end
    end else if (m_drain) begin
      if (b) n_tgt = ba_al;
      if (rdy) begin
        n_pc    = b ? ba_al : m_tgt;
        n_drain = 1'b0;
      end
    end else if (rdy) begin
      if (b) n_pc = ba_al;
      else if (f) n_held = 1'b1;
      else deliver = 1'b1;
    end else if (b) begin
      n_drain = 1'b1;
      n_tgt   = ba_al;
    end
    if (deliver) n_pc = m_pc + 32'd4;

    if (fl || b) begin
      m_valid = 1'b0;
    end else if (f) begin
      m_valid = m_valid;
    end else if (deliver) begin
      m_valid  = 1'b1;
      m_opc    = m_pc + 32'd4;
      m_oinstr = m_pc ^ KEY;
    end else begin
      m_valid = 1'b0;
    end
    m_pc    = n_pc;
    m_drain = n_drain;
    m_tgt   = n_tgt;
    m_held  = n_held;

    @(posedge clk);
    #1;
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_pc", if_pc, m_opc);
    check("if_instr", if_instr, m_oinstr);
    if (if_valid) $display("fetch: if_pc=%h instr=%h", if_pc, if_instr);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ba;
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    bt = 1'b0;
    baddr = 32'h0;
    ifc.imem_ready = 1'b1;
    ifc.imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_imem_req", 32'(ifc.imem_req), 32'h1);
    check("rst_imem_addr", ifc.imem_addr, 32'h0);
    rst = 1'b0;

    // Zero-wait memory: one instruction per cycle from the first edge.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("zw_valid", 32'(if_valid), 32'h1);
      check("zw_pc", if_pc, 32'(4 * (i + 1)));
      check("zw_instr", if_instr, (32'(4 * i)) ^ KEY);
    end

    // Ready every third cycle.
    for (int i = 0; i < 12; i++) begin
      step(i % 3 == 2, 1'b0, 1'b0, 1'b0, 32'h0);
      check("ws_valid", 32'(if_valid), 32'(i % 3 == 2));
    end

    // Redirect while waiting: stale word dropped, target fetched after ready.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_no_valid", 32'(if_valid), 32'h0);
    check("drain_addr", ifc.imem_addr, 32'h100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_pc", if_pc, 32'h104);

    // Freeze across a response, then release.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("hold_req", 32'(ifc.imem_req), 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_release_pc", if_pc, 32'h108);
    check("hold_release_instr", if_instr, 32'h104 ^ KEY);

    // Single-cycle flush with zero-wait memory.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("flush_bubble", 32'(if_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("flush_resume_pc", if_pc, 32'h110);

    // Randomized mix of wait states, freezes, flushes and redirects.
    for (int i = 0; i < 3000; i++) begin
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, ba);
    end

    // Return to FETCH, then check the PC wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_addr_hi", ifc.imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_if_pc", if_pc, 32'h0);
    check("wrap_addr", ifc.imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a drained redirect.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    #2;
    rst = 1'b1;
    #1;
    check("arst_if_valid", 32'(if_valid), 32'h0);
    check("arst_if_pc", if_pc, 32'h0);
    check("arst_if_instr", if_instr, 32'h0);
    check("arst_imem_req", 32'(ifc.imem_req), 32'h1);
    check("arst_imem_addr", ifc.imem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    check("post_rst_pc", if_pc, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
